// File: rtl/mux_scan_pkg.sv
// Shared definitions for the 4:1 mux scan sequencer.
// Channel count, channel index width, FSM encoding and the cleared frame value.
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scanState_t;

  localparam logic [NUM_CH-1:0] RESET_FRAME = 4'b0000;

endpackage

// File: rtl/scan_slot_timer.sv
// Per-channel settle timer: flags the last cycle of each SETTLE_CYCLES+1 long slot.
// 'clear' restarts the slot count when a new scan begins.
module scan_slot_timer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic slot_done
);

  logic [CNT_W-1:0] count;

  assign slot_done = enable && (count == CNT_W'(SETTLE_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (slot_done) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps the selects through every channel, samples y
// into a 4-bit frame and offers it downstream on a valid/ready handshake.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  y,
  output logic                  s0,
  output logic                  s1,
  output logic                  busy,
  output logic [NUM_CH-1:0]     frame_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  overrun
);

  scanState_t       state, nextState;
  logic [CH_W-1:0]  channel;
  logic [NUM_CH-1:0] asmReg, asmNext;
  logic             slotDone;
  logic             startAccept;
  logic             frameDone;
  logic             frameLoad;

  scan_slot_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .enable   (state == ST_SCAN),
    .clear    (startAccept),
    .slot_done(slotDone)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // A frame completes on the slot that samples the last channel; it only lands
  // in the output register if that register is empty or being drained this cycle.
  always_comb begin
    nextState   = state;
    startAccept = 1'b0;
    asmNext     = asmReg;
    asmNext[channel] = y;
    frameDone   = slotDone && (channel == CH_W'(NUM_CH - 1));
    frameLoad   = frameDone && (!frame_valid || frame_ready);
    busy        = (state != ST_IDLE);
    {s1, s0}    = (state == ST_SCAN) ? channel : '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          startAccept = 1'b1;
          nextState   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (frameDone && !continuous) begin
          nextState = ST_IDLE;
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      channel     <= '0;
      asmReg      <= RESET_FRAME;
      frame_data  <= RESET_FRAME;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (startAccept) begin
        channel <= '0;
        overrun <= 1'b0;
      end
      // The 2-bit channel wraps 3->0 exactly on the completing slot.
      if (slotDone) begin
        asmReg  <= asmNext;
        channel <= channel + 1'b1;
      end
      if (frameLoad) begin
        frame_data  <= asmNext;
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
      if (frameDone && !frameLoad) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: a behavioural 4:1 mux feeds y back, and expected
// frames are queued when a scan is launched and popped when a frame appears.
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start, continuous, frameReady;
  logic [3:0] muxIn;
  logic       y, s0, s1, busy, frameValid, overrun;
  logic [3:0] frameData;

  logic       start0, continuous0, frameReady0;
  logic [3:0] muxIn0;
  logic       y0, s0_0, s1_0, busy0, frameValid0, overrun0;
  logic [3:0] frameData0;

  int         checks;
  int         errors;
  logic [3:0] expQ[$];

  mux_scan_ctrl #(.SETTLE_CYCLES(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .y(y),
    .s0(s0), .s1(s1), .busy(busy), .frame_data(frameData),
    .frame_valid(frameValid), .frame_ready(frameReady), .overrun(overrun)
  );

  mux_scan_ctrl #(.SETTLE_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .continuous(continuous0), .y(y0),
    .s0(s0_0), .s1(s1_0), .busy(busy0), .frame_data(frameData0),
    .frame_valid(frameValid0), .frame_ready(frameReady0), .overrun(overrun0)
  );

  assign y  = muxIn[{s1, s0}];
  assign y0 = muxIn0[{s1_0, s0_0}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation hung");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic cont, input logic rdy,
                               input logic [3:0] pattern);
    start      = st;
    continuous = cont;
    frameReady = rdy;
    muxIn      = pattern;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkFrame(input string tag, input logic [3:0] obs);
    logic [3:0] exp;
    if (expQ.size() == 0) begin
      checkOutput({tag, " (queue empty)"}, 8'(obs), 8'hFF);
    end else begin
      exp = expQ.pop_front();
      checkOutput(tag, 8'(obs), 8'(exp));
    end
  endtask

  initial begin
    int busyCnt;
    int validCnt;
    checks = 0;
    errors = 0;
    start0 = 1'b0; continuous0 = 1'b0; frameReady0 = 1'b1; muxIn0 = 4'b1010;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
    rst = 1'b1;
    tick(2);
    checkOutput("rst sel", 8'({s1, s0}), 8'd0);
    checkOutput("rst busy", 8'(busy), 8'd0);
    checkOutput("rst data", 8'(frameData), 8'd0);
    checkOutput("rst valid", 8'(frameValid), 8'd0);
    checkOutput("rst overrun", 8'(overrun), 8'd0);
    rst = 1'b0;
    tick(1);

    $display("[TB] single-shot scan, settle 1");
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b1101);
    expQ.push_back(4'b1101);
    tick(1);
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      checkOutput($sformatf("t1 sel c%0d", c), 8'({s1, s0}), 8'((c - 1) / 2));
      checkOutput($sformatf("t1 busy c%0d", c), 8'(busy), 8'd1);
      checkOutput($sformatf("t1 valid c%0d", c), 8'(frameValid), 8'd0);
      tick(1);
    end
    checkOutput("t1 valid c9", 8'(frameValid), 8'd1);
    checkOutput("t1 busy c9", 8'(busy), 8'd0);
    checkFrame("t1 data", frameData);
    tick(1);
    checkOutput("t1 valid c10", 8'(frameValid), 8'd0);

    $display("[TB] start held three cycles");
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0110);
    expQ.push_back(4'b0110);
    busyCnt  = 0;
    validCnt = 0;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      if (c == 3) start = 1'b0;
      if (busy) busyCnt++;
      if (frameValid) begin
        validCnt++;
        if (validCnt == 1) checkFrame("t2 data", frameData);
      end
    end
    checkOutput("t2 busy cycles", 8'(busyCnt), 8'd8);
    checkOutput("t2 frame count", 8'(validCnt), 8'd1);

    $display("[TB] continuous scan with stalled sink");
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0011);
    expQ.push_back(4'b0011);
    tick(1);
    start = 1'b0;
    tick(8);
    checkOutput("t3 valid f1", 8'(frameValid), 8'd1);
    checkFrame("t3 data f1", frameData);
    muxIn = 4'b1000;
    tick(7);
    checkOutput("t3 overrun pre", 8'(overrun), 8'd0);
    tick(1);
    checkOutput("t3 overrun set", 8'(overrun), 8'd1);
    checkOutput("t3 data held", 8'(frameData), 8'h03);
    checkOutput("t3 valid held", 8'(frameValid), 8'd1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checkOutput("t3 busy start ignored", 8'(busy), 8'd1);
    checkOutput("t3 overrun kept", 8'(overrun), 8'd1);
    continuous = 1'b0;
    for (int i = 0; i < 40 && busy; i++) tick(1);
    checkOutput("t3 reach idle", 8'(busy), 8'd0);
    checkOutput("t3 overrun idle", 8'(overrun), 8'd1);
    checkOutput("t3 data idle", 8'(frameData), 8'h03);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0111);
    expQ.push_back(4'b0111);
    tick(1);
    start = 1'b0;
    checkOutput("t3 overrun cleared", 8'(overrun), 8'd0);
    checkOutput("t3 valid drained", 8'(frameValid), 8'd0);
    tick(8);
    checkOutput("t3 valid restart", 8'(frameValid), 8'd1);
    checkFrame("t3 data restart", frameData);
    tick(1);

    $display("[TB] ready on the completion cycle");
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0101);
    expQ.push_back(4'b0101);
    tick(1);
    start = 1'b0;
    tick(8);
    checkOutput("t4 valid fA", 8'(frameValid), 8'd1);
    checkFrame("t4 data fA", frameData);
    muxIn = 4'b1110;
    expQ.push_back(4'b1110);
    tick(7);
    frameReady = 1'b1;
    continuous = 1'b0;
    tick(1);
    checkOutput("t4 valid kept", 8'(frameValid), 8'd1);
    checkFrame("t4 data fB", frameData);
    checkOutput("t4 overrun", 8'(overrun), 8'd0);
    checkOutput("t4 busy", 8'(busy), 8'd0);
    tick(1);
    checkOutput("t4 valid drained", 8'(frameValid), 8'd0);

    $display("[TB] reset during channel 2");
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0110);
    tick(1);
    start = 1'b0;
    tick(4);
    checkOutput("t5 sel ch2", 8'({s1, s0}), 8'd2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("t5 sel", 8'({s1, s0}), 8'd0);
    checkOutput("t5 busy", 8'(busy), 8'd0);
    checkOutput("t5 data", 8'(frameData), 8'd0);
    checkOutput("t5 valid", 8'(frameValid), 8'd0);
    checkOutput("t5 overrun", 8'(overrun), 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b1001);
    expQ.push_back(4'b1001);
    tick(1);
    start = 1'b0;
    tick(8);
    checkOutput("t5 valid fresh", 8'(frameValid), 8'd1);
    checkFrame("t5 data fresh", frameData);

    $display("[TB] continuous scan, settle 0");
    start0 = 1'b1;
    continuous0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      expQ.push_back(4'b1010);
      for (int j = 0; j < 4; j++) begin
        checkOutput($sformatf("t6 busy f%0d", k), 8'(busy0), 8'd1);
        tick(1);
      end
      checkOutput($sformatf("t6 valid f%0d", k), 8'(frameValid0), 8'd1);
      checkFrame($sformatf("t6 data f%0d", k), frameData0);
      checkOutput($sformatf("t6 overrun f%0d", k), 8'(overrun0), 8'd0);
    end
    continuous0 = 1'b0;
    for (int i = 0; i < 20 && busy0; i++) tick(1);
    checkOutput("t6 reach idle", 8'(busy0), 8'd0);

    checkOutput("scoreboard drained", 8'(expQ.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer that sits directly upstream of the 4:1 mux. Drives its select lines s1:s0 through channels 0..3 and samples the mux output y back.
- Packs the four sampled bits into a 4-bit frame and presents it downstream on a valid/ready handshake.
- Supports single-shot and continuous scanning, a programmable select-settle time, and overrun detection.

Parameters:
- SETTLE_CYCLES, 1, extra cycles the select is held before y is sampled; range 0..15.
- CNT_W, 4, width of the settle counter; must satisfy 2**CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a scan; honoured only in IDLE.
- continuous  input  1  when 1 at end of a frame, the next frame starts immediately.
- y  input  1  mux output fed back for sampling.
- s0  output  1  select LSB (channel bit 0).
- s1  output  1  select MSB (channel bit 1).
- busy  output  1  high whenever state is not IDLE.
- frame_data  output  4  bit n = y sampled while channel n was selected.
- frame_valid  output  1  frame_data holds an unconsumed frame.
- frame_ready  input  1  downstream accepts the frame when frame_valid and frame_ready are both high.
- overrun  output  1  sticky: a completed frame was dropped because the output register was still full.

Behaviour:
- Reset (rst=1 at a clock edge) forces the following, regardless of state, aborting any scan in progress:
  - state=IDLE, channel=0, settle count=0
  - s1:s0=00, busy=0, frame_data=0000, frame_valid=0, overrun=0
  - assembly register=0000
- States:
  - IDLE: s1:s0=00. start=1 moves to SCAN with channel=0 and count=0, and clears overrun on the same edge.
  - SCAN: s1:s0 equals the current channel throughout that channel's slot.
- Slot timing:
  - Each channel slot lasts SETTLE_CYCLES+1 cycles.
  - The count increments each cycle. On the slot's last cycle (count==SETTLE_CYCLES), y is captured into assembly bit [channel], count resets to 0 and channel increments.
  - With SETTLE_CYCLES=0, one channel is sampled per cycle.
- Frame completion occurs on the edge that samples channel 3:
  - If frame_valid=0, or frame_valid=1 and frame_ready=1 in that same cycle, then frame_data is loaded with the full frame (including the bit just sampled) and frame_valid=1 next cycle.
  - Otherwise the new frame is discarded, frame_data is unchanged, and overrun is set to 1.
  - Then, if continuous=1, stay in SCAN with channel=0 (no idle gap). Else go to IDLE.
- Channel wraps 3→0 only at frame completion; the channel counter is exactly 2 bits.
- Handshake:
  - frame_valid clears on an edge with frame_valid and frame_ready both high, unless a new frame loads on that same edge, in which case frame_valid stays 1.
  - frame_data is stable while frame_valid=1 and frame_ready=0.
- Control inputs:
  - start while busy is ignored.
  - continuous is sampled only at frame completion.
  - Deasserting continuous mid-frame finishes the current frame, then goes to IDLE.
- Overrun clears only on rst or on an accepted start.
- Latency, single-shot: with start high in cycle 0, frame_valid is first high in cycle 4*(SETTLE_CYCLES+1)+1. For SETTLE_CYCLES=1, that is cycle 9.
- busy deasserts in the same cycle frame_valid first rises (single-shot).

Decomposition:
- Shared package mux_scan_pkg holds:
  - NUM_CH=4 and CH_W=2
  - state encoding ST_IDLE=1'b0, ST_SCAN=1'b1
  - a constant for the reset frame value 4'b0000
- One sub-module, scan_slot_timer:
  - inputs: clk, rst, enable, clear
  - output: slot_done, asserted on the last cycle of a slot
  - parameter: SETTLE_CYCLES
- The top level holds the FSM, channel counter, assembly register and output register.

Test Plan:
- SETTLE=1, start pulse, y driven per channel as ch0=1, ch1=0, ch2=1, ch3=1 with frame_ready=1. Required: s1:s0 sequence 00,00,01,01,10,10,11,11; frame_data=4'b1101; frame_valid high in cycle 9 only; busy low from cycle 9.
- SETTLE=0, continuous=1, frame_ready=1, y=channel[0]. Required: frame_data=4'b1010 every 4 cycles; frame_valid high continuously after the first frame; s never returns to IDLE.
- Continuous scan with frame_ready held 0. Required: first frame held stable; overrun=1 at end of frame 2; frame_data still frame 1. Then start while busy is ignored; deassert continuous, wait for IDLE, pulse start: overrun returns to 0.
- frame_ready asserted exactly on the frame-completion cycle of the next frame. Required: new frame loads; frame_valid stays 1; overrun stays 0.
- rst=1 in the middle of channel 2. Required next cycle: all outputs at reset values; a following start produces a fresh, correct frame from channel 0.
- start=1 held for 3 cycles in single-shot mode. Required: exactly one scan; busy=1 for 4*(SETTLE+1) cycles.
